// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter feeding four byte-wide requesters into one 8-bit FIFO write port.
// Define FIFO_ARB_BURST_LOCK_EN to keep a grant until the beat marked by last is written.
module fifo_wr_arbiter (
   input  logic        clk,
   input  logic        rst_,
   input  logic [3:0]  req,
   input  logic [3:0]  last,
   input  logic [31:0] din,
   input  logic        fifo_full,
   output logic [3:0]  gnt,
   output logic        fifo_wen,
   output logic [7:0]  fifo_din,
   output logic [1:0]  cur_id,
   output logic [15:0] beats
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t      state_reg, state_next;
   logic [3:0]  gnt_reg, gnt_next;
   logic [1:0]  cur_id_reg, cur_id_next;
   logic [1:0]  ptr_reg, ptr_next;
   logic [15:0] beats_reg, beats_next;

   logic [7:0]  din_bytes [4];
   logic        accept;
   logic        release_grant;
   logic [1:0]  search_start;
   logic        pick_found;
   logic [1:0]  pick_idx;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
         assign din_bytes[gi] = din[8*gi +: 8];
      end
   endgenerate

   // Returns {found, index}: first set bit of r walking start, start+1, ... mod 4.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
      logic [1:0] idx;
      rr_pick = 3'b000;
      for (int o = 3; o >= 0; o--) begin
         idx = start + 2'(o);
         if (r[idx]) begin
            rr_pick = {1'b1, idx};
         end
      end
   endfunction

   assign accept   = (|(gnt_reg & req)) & ~fifo_full;
   assign fifo_wen = accept;
   assign fifo_din = din_bytes[cur_id_reg];

`ifdef FIFO_ARB_BURST_LOCK_EN
   assign release_grant = accept & last[cur_id_reg];
`else
   // last is meaningless when every beat is its own burst.
   logic unused_last;
   assign unused_last   = ^last;
   assign release_grant = (state_reg == BUSY) & (accept | ~req[cur_id_reg]);
`endif

   // A released requester re-enters the search at the lowest priority.
   assign search_start = (state_reg == BUSY) ? (cur_id_reg + 2'd1) : ptr_reg;
   assign {pick_found, pick_idx} = rr_pick(req, search_start);

   always_comb begin
      state_next  = state_reg;
      gnt_next    = gnt_reg;
      cur_id_next = cur_id_reg;
      ptr_next    = ptr_reg;
      beats_next  = beats_reg + 16'(accept);
      case (state_reg)
         IDLE: begin
            if (pick_found) begin
               state_next  = BUSY;
               gnt_next    = 4'b0001 << pick_idx;
               cur_id_next = pick_idx;
            end
         end
         BUSY: begin
            if (release_grant) begin
               ptr_next = cur_id_reg + 2'd1;
               if (pick_found) begin
                  gnt_next    = 4'b0001 << pick_idx;
                  cur_id_next = pick_idx;
               end else begin
                  state_next  = IDLE;
                  gnt_next    = 4'b0000;
                  cur_id_next = 2'd0;
               end
            end
         end
         default: begin
            state_next  = IDLE;
            gnt_next    = 4'b0000;
            cur_id_next = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_reg  <= IDLE;
         gnt_reg    <= 4'b0000;
         cur_id_reg <= 2'd0;
         ptr_reg    <= 2'd0;
         beats_reg  <= 16'd0;
      end else begin
         state_reg  <= state_next;
         gnt_reg    <= gnt_next;
         cur_id_reg <= cur_id_next;
         ptr_reg    <= ptr_next;
         beats_reg  <= beats_next;
      end
   end

   assign gnt    = gnt_reg;
   assign cur_id = cur_id_reg;
   assign beats  = beats_reg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: predicted writes are queued as stimulus is driven
// and popped when the DUT asserts fifo_wen.
module tb_fifo_wr_arbiter;

   logic        clk;
   logic        rst_;
   logic [3:0]  req;
   logic [3:0]  last;
   logic [31:0] din;
   logic        fifo_full;
   logic [3:0]  gnt;
   logic        fifo_wen;
   logic [7:0]  fifo_din;
   logic [1:0]  cur_id;
   logic [15:0] beats;

   int          n_asserts;
   int          n_fail;
   logic [15:0] exp_beats;
   logic [9:0]  sb[$];

   fifo_wr_arbiter dut (
      .clk       (clk),
      .rst_      (rst_),
      .req       (req),
      .last      (last),
      .din       (din),
      .fifo_full (fifo_full),
      .gnt       (gnt),
      .fifo_wen  (fifo_wen),
      .fifo_din  (fifo_din),
      .cur_id    (cur_id),
      .beats     (beats)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [1:0] idx_of(input logic [3:0] g);
      idx_of = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (g[i]) idx_of = 2'(i);
      end
   endfunction

   // Write monitor: every FIFO write must match the oldest predicted one.
   always @(negedge clk) begin
      logic [9:0] e;
      if (rst_ && fifo_wen) begin
         check_eq("sb_nonempty", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("wr_data", 32'(fifo_din), 32'(e[7:0]));
            check_eq("wr_id", 32'(cur_id), 32'(e[9:8]));
            $display("write id=%0d data=0x%02h beats=%0d", cur_id, fifo_din, beats);
         end
      end
   end

   // One clock cycle: drive inputs, check registered/combinational outputs, predict the write.
   task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic full,
                      input logic [3:0] exp_gnt, input logic exp_wr);
      logic [1:0] id;
      @(posedge clk);
      #1;
      req       = r;
      last      = l;
      fifo_full = full;
      din       = $urandom;
      #2;
      id = idx_of(exp_gnt);
      check_eq("gnt", 32'(gnt), 32'(exp_gnt));
      check_eq("cur_id", 32'(cur_id), 32'(id));
      check_eq("fifo_wen", 32'(fifo_wen), 32'(exp_wr));
      check_eq("beats", 32'(beats), 32'(exp_beats));
      if (exp_wr) begin
         sb.push_back({id, din[8*id +: 8]});
         exp_beats = exp_beats + 16'd1;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_      = 1'b0;
      req       = 4'h0;
      last      = 4'h0;
      fifo_full = 1'b0;
      #1;
      check_eq("rst_gnt", 32'(gnt), 32'd0);
      check_eq("rst_cur_id", 32'(cur_id), 32'd0);
      check_eq("rst_beats", 32'(beats), 32'd0);
      check_eq("rst_wen", 32'(fifo_wen), 32'd0);
      exp_beats = 16'd0;
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_ = 1'b1;
   endtask

   initial begin
      n_asserts = 0;
      n_fail    = 0;
      exp_beats = 16'd0;
      rst_      = 1'b0;
      req       = 4'h0;
      last      = 4'h0;
      din       = 32'h0;
      fifo_full = 1'b0;

      // Idle after reset
      do_reset();
      repeat (5) cyc(4'h0, 4'h0, 1'b0, 4'b0000, 1'b0);

      // All requesting, one beat each: plain rotation
      cyc(4'hF, 4'hF, 1'b0, 4'b0000, 1'b0);
      cyc(4'hF, 4'hF, 1'b0, 4'b0001, 1'b1);
      cyc(4'hF, 4'hF, 1'b0, 4'b0010, 1'b1);
      cyc(4'hF, 4'hF, 1'b0, 4'b0100, 1'b1);
      cyc(4'hF, 4'hF, 1'b0, 4'b1000, 1'b1);
      cyc(4'hF, 4'hF, 1'b0, 4'b0001, 1'b1);

      // Search order from ptr: 2 before 3, then wrap back to 2
      do_reset();
      cyc(4'hC, 4'hF, 1'b0, 4'b0000, 1'b0);
      cyc(4'hC, 4'hF, 1'b0, 4'b0100, 1'b1);
      cyc(4'hC, 4'hF, 1'b0, 4'b1000, 1'b1);
      cyc(4'hC, 4'hF, 1'b0, 4'b0100, 1'b1);
      cyc(4'h0, 4'hF, 1'b0, 4'b1000, 1'b0);
`ifdef FIFO_ARB_BURST_LOCK_EN
      cyc(4'h0, 4'hF, 1'b0, 4'b1000, 1'b0);
`else
      cyc(4'h0, 4'hF, 1'b0, 4'b0000, 1'b0);
`endif

      // FIFO full stalls a granted requester
      do_reset();
      cyc(4'h2, 4'hF, 1'b1, 4'b0000, 1'b0);
      repeat (4) cyc(4'h2, 4'hF, 1'b1, 4'b0010, 1'b0);
      cyc(4'h2, 4'hF, 1'b0, 4'b0010, 1'b1);
      cyc(4'h0, 4'hF, 1'b0, 4'b0010, 1'b0);
`ifdef FIFO_ARB_BURST_LOCK_EN
      cyc(4'h0, 4'hF, 1'b0, 4'b0010, 1'b0);
`else
      cyc(4'h0, 4'hF, 1'b0, 4'b0000, 1'b0);
`endif

`ifdef FIFO_ARB_BURST_LOCK_EN
      // Three-beat burst from 0 while 2 waits; 2 then holds through a req gap
      do_reset();
      cyc(4'h5, 4'h0, 1'b0, 4'b0000, 1'b0);
      cyc(4'h5, 4'h0, 1'b0, 4'b0001, 1'b1);
      cyc(4'h5, 4'h0, 1'b0, 4'b0001, 1'b1);
      cyc(4'h5, 4'h1, 1'b0, 4'b0001, 1'b1);
      cyc(4'h1, 4'h0, 1'b0, 4'b0100, 1'b0);
      cyc(4'h1, 4'h0, 1'b0, 4'b0100, 1'b0);
      cyc(4'h5, 4'h4, 1'b0, 4'b0100, 1'b1);
      cyc(4'h0, 4'h0, 1'b0, 4'b0001, 1'b0);
`endif

      // Asynchronous reset in the middle of requester 3's traffic
      do_reset();
      cyc(4'h8, 4'h0, 1'b0, 4'b0000, 1'b0);
      cyc(4'h8, 4'h0, 1'b0, 4'b1000, 1'b1);
      cyc(4'h8, 4'h0, 1'b0, 4'b1000, 1'b1);
      @(posedge clk);
      #1;
      rst_ = 1'b0;
      req  = 4'h9;
      #1;
      check_eq("async_rst_gnt", 32'(gnt), 32'd0);
      check_eq("async_rst_beats", 32'(beats), 32'd0);
      check_eq("async_rst_wen", 32'(fifo_wen), 32'd0);
      exp_beats = 16'd0;
      sb.delete();
      @(posedge clk);
      #1;
      rst_ = 1'b1;
      #1;
      check_eq("no_grant_before_edge", 32'(gnt), 32'd0);
      cyc(4'h9, 4'h0, 1'b0, 4'b0001, 1'b1);
`ifdef FIFO_ARB_BURST_LOCK_EN
      cyc(4'h0, 4'h0, 1'b0, 4'b0001, 1'b0);
`else
      cyc(4'h0, 4'h0, 1'b0, 4'b1000, 1'b0);
`endif

      // Beat counter wrap after 65536 writes
      do_reset();
      cyc(4'h1, 4'h0, 1'b0, 4'b0000, 1'b0);
      for (int i = 0; i < 65536; i++) begin
         cyc(4'h1, 4'h0, 1'b0, 4'b0001, 1'b1);
      end
      @(posedge clk);
      #1;
      req = 4'h0;
      #2;
      check_eq("beats_wrap", 32'(beats), 32'h0000_0000);

      @(posedge clk);
      #1;
      check_eq("sb_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; rst_  input  1  asynchronous active-low reset.
REQ-002 The block SHALL have port req  input  4  per-requester write request, bit i = requester i.
REQ-003 The block SHALL have port last  input  4  bit i high marks requester i's current beat as final beat of its burst.
REQ-004 The block SHALL have port din  input  32  requester data, din[8i+7:8i] = requester i byte.
REQ-005 The block SHALL have port fifo_full  input  1  full flag of the downstream 8-bit FIFO write port.
REQ-006 The block SHALL have port gnt  output  4  registered one-hot grant (all-zero when idle).
REQ-007 The block SHALL have port fifo_wen  output  1  FIFO write enable.
REQ-008 The block SHALL have port fifo_din  output  8  FIFO write data.
REQ-009 The block SHALL have port cur_id  output  2  index of the granted requester, 0 when idle.
REQ-010 The block SHALL have port beats  output  16  count of accepted beats since reset, wraps 0xFFFF->0.

Function
REQ-011 FSM states SHALL be IDLE (gnt=0) and BUSY (gnt one-hot).
REQ-012 A beat SHALL be accepted in any cycle where gnt[i] & req[i] & !fifo_full.
REQ-013 fifo_wen SHALL equal the accept condition combinationally, and fifo_din SHALL equal din byte cur_id, with zero added latency.
REQ-014 fifo_wen SHALL be 0 whenever fifo_full=1 or gnt=0, and fifo_din SHALL be don't-care when fifo_wen=0.
REQ-015 Round-robin pointer ptr[1:0] SHALL hold the highest-priority index; the search order SHALL be ptr, ptr+1, ptr+2, ptr+3 mod 4.
REQ-016 In IDLE with any req bit set, the next edge SHALL grant the first requesting index in search order and enter BUSY.
REQ-017 On grant release from index k, ptr SHALL become k+1 mod 4.
REQ-018 On release, if any req (including k) is set, the next grant SHALL be issued on the same edge with no idle bubble, searching from k+1. Otherwise the FSM SHALL enter IDLE.
REQ-019 gnt SHALL change only at a clock edge, and at most one bit SHALL ever be high.
REQ-020 beats SHALL increment by 1 on every accepted beat.
REQ-021 fifo_full high while granted SHALL stall without releasing the grant, and the held beat SHALL be accepted in the first cycle fifo_full is low with req still high.

Reset
REQ-022 Asserting rst_ low SHALL immediately force gnt=0, cur_id=0, ptr=0, beats=0, state IDLE, and therefore fifo_wen=0.
REQ-023 Reset mid-burst SHALL abandon the burst; after release the block SHALL re-arbitrate from ptr=0.
REQ-024 The first grant SHALL occur no earlier than the first rising edge after rst_ deasserts.

Configuration
REQ-025 Macro FIFO_ARB_BURST_LOCK_EN SHALL select the burst-lock feature.
REQ-026 With FIFO_ARB_BURST_LOCK_EN defined:
- The grant SHALL release only on an accepted beat with last[k]=1.
- req[k] low while granted SHALL stall without release.
- Bursts SHALL be written contiguously to the FIFO.
REQ-027 Without FIFO_ARB_BURST_LOCK_EN:
- The grant SHALL release after every accepted beat.
- The grant SHALL also release in any granted cycle with req[k]=0.
- last SHALL be ignored.

Verification
REQ-028 Scenario: reset, req=4'b0000 for 5 cycles -> gnt=0, fifo_wen=0, beats=0 throughout.
REQ-029 Scenario: req=4'b1111 held, fifo_full=0, lock off -> gnt sequence 0001,0010,0100,1000,0001, fifo_din follows din bytes, beats increments each cycle.
REQ-030 Scenario: lock on; req0 sends 3 beats (last on 3rd) while req2 also requests -> 3 consecutive writes from req0, then gnt=0100 on the next edge with no bubble, ptr=1.
REQ-031 Scenario: granted req1, fifo_full=1 for 4 cycles -> fifo_wen=0, gnt stays 0010, beats unchanged. The beat is written on the first cycle full drops.
REQ-032 Scenario: lock on, rst_ pulsed low mid-burst of req3 -> gnt=0 asynchronously, beats=0. After release with req=4'b1001, the first grant is 0001.
REQ-033 Scenario: 65536 accepted beats -> beats wraps to 0x0000.
